// File: rtl/frame_reflector_pkg.sv
// frame_reflector_pkg: shared frame offsets, beat struct, FSM states and checksum helper
package frame_reflector_pkg;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam int ETH_DST_OFF  = 0;
  localparam int ETH_SRC_OFF  = 6;
  localparam int ETH_TYPE_OFF = 12;
  localparam int IP_VER_OFF   = 14;
  localparam int IP_TTL_OFF   = 22;
  localparam int IP_CSUM_OFF  = 24;
  localparam int IP_SRC_OFF   = 26;
  localparam int IP_DST_OFF   = 30;
  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [63:0]  user;
    logic         last;
  } axis_beat_t;
  typedef enum logic [1:0] {FIRST, PASS, DROP} state_t;
  // One's-complement +0x0100 for a TTL decrement; 0xFFFF is kept as-is.
  function automatic logic [15:0] csum_ttl_dec(input logic [15:0] c);
    logic [16:0] s;
    s = {1'b0, c} + 17'h00100;
    return (c == 16'hFFFF) ? c : s[15:0] + {15'd0, s[16]};
  endfunction
endpackage

// File: rtl/frame_reflector_skid.sv
// axis_skid_buffer: output register plus skid register, full throughput, 1-cycle latency
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  logic         r_skid_valid;
  logic [W-1:0] r_skid;
  logic         w_in_fire;
  logic         w_load;
  logic         w_skid_next;
  assign w_in_fire   = i_valid && o_ready;
  assign w_load      = !o_valid || i_ready;
  assign w_skid_next = !w_load && (r_skid_valid || w_in_fire);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ready      <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
    end else begin
      o_ready      <= !w_skid_next;
      r_skid_valid <= w_skid_next;
      if (w_load) begin
        o_valid <= r_skid_valid || w_in_fire;
        if (r_skid_valid) o_data <= r_skid;
        else if (w_in_fire) o_data <= i_data;
      end else if (w_in_fire) begin
        r_skid <= i_data;
      end
    end
  end
endmodule

// File: rtl/frame_reflector.sv
// frame_reflector: swaps MAC/IP, decrements TTL, patches checksum, drops unreflectable frames.
// FRAME_REFLECTOR_STATS_EN adds byte_count and ttl_drop_count outputs.
module frame_reflector
  import frame_reflector_pkg::*;
#(
  parameter logic [2:0] OUT_ID  = 3'd0,
  parameter logic [7:0] MIN_TTL = 8'd2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         axis_s_valid,
  output logic         axis_s_ready,
  input  logic [511:0] axis_s_data,
  input  logic [63:0]  axis_s_keep,
  input  logic [63:0]  axis_s_user,
  input  logic [2:0]   axis_s_id,
  input  logic         axis_s_last,
  output logic         axis_m_valid,
  input  logic         axis_m_ready,
  output logic [511:0] axis_m_data,
  output logic [63:0]  axis_m_keep,
  output logic [63:0]  axis_m_user,
  output logic [2:0]   axis_m_id,
  output logic         axis_m_last,
  output logic [31:0]  reflected_count,
  output logic [31:0]  dropped_count
`ifdef FRAME_REFLECTOR_STATS_EN
  ,
  output logic [47:0]  byte_count,
  output logic [31:0]  ttl_drop_count
`endif
);
  state_t     r_state, w_next;
  axis_beat_t w_in, w_out;
  logic       w_s_fire, w_hdr_ok, w_ttl_ok, w_ok, w_fwd, w_skid_ready, w_first;
  logic [7:0]  w_ttl;
  logic [15:0] w_csum;
  logic [31:0] r_reflected, r_dropped;
  assign w_ttl    = axis_s_data[8*IP_TTL_OFF +: 8];
  assign w_csum   = {axis_s_data[8*IP_CSUM_OFF +: 8], axis_s_data[8*(IP_CSUM_OFF+1) +: 8]};
  assign w_hdr_ok = (&axis_s_keep[33:0])
                 && {axis_s_data[8*ETH_TYPE_OFF +: 8], axis_s_data[8*(ETH_TYPE_OFF+1) +: 8]} == ETHERTYPE_IPV4
                 && axis_s_data[8*IP_VER_OFF +: 8] == IP_VER_IHL;
  assign w_ttl_ok = w_ttl >= MIN_TTL;
  assign w_ok     = enable && w_hdr_ok && w_ttl_ok;
  assign w_first  = r_state == FIRST;
  assign w_fwd    = r_state == PASS || (w_first && w_ok);
  // DROP swallows beats regardless of downstream backpressure.
  assign axis_s_ready = w_skid_ready || r_state == DROP;
  assign w_s_fire     = axis_s_valid && axis_s_ready;
  always_comb begin
    w_in = {axis_s_data, axis_s_keep, axis_s_user, axis_s_last};
    if (w_first) begin
      w_in.data[8*ETH_DST_OFF +: 48] = axis_s_data[8*ETH_SRC_OFF +: 48];
      w_in.data[8*ETH_SRC_OFF +: 48] = axis_s_data[8*ETH_DST_OFF +: 48];
      w_in.data[8*IP_SRC_OFF +: 32]  = axis_s_data[8*IP_DST_OFF +: 32];
      w_in.data[8*IP_DST_OFF +: 32]  = axis_s_data[8*IP_SRC_OFF +: 32];
      w_in.data[8*IP_TTL_OFF +: 8]   = w_ttl - 8'd1;
      {w_in.data[8*IP_CSUM_OFF +: 8], w_in.data[8*(IP_CSUM_OFF+1) +: 8]} = csum_ttl_dec(w_csum);
    end
  end
  axis_skid_buffer #(.W($bits(axis_beat_t))) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (axis_s_valid && w_fwd),
    .o_ready (w_skid_ready),
    .i_data  (w_in),
    .o_valid (axis_m_valid),
    .i_ready (axis_m_ready),
    .o_data  (w_out)
  );
  assign axis_m_data = w_out.data;
  assign axis_m_keep = w_out.keep;
  assign axis_m_user = w_out.user;
  assign axis_m_last = w_out.last;
  assign axis_m_id   = OUT_ID;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FIRST;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_s_fire) w_next = axis_s_last ? FIRST : w_first ? (w_ok ? PASS : DROP) : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reflected <= '0;
      r_dropped   <= '0;
    end else if (w_s_fire && w_first) begin
      if (w_ok) r_reflected <= r_reflected + 32'd1;
      else r_dropped <= r_dropped + 32'd1;
    end
  end
  assign reflected_count = r_reflected;
  assign dropped_count   = r_dropped;
`ifdef FRAME_REFLECTOR_STATS_EN
  logic [47:0] r_bytes;
  logic [31:0] r_ttl_drops;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bytes     <= '0;
      r_ttl_drops <= '0;
    end else begin
      if (axis_m_valid && axis_m_ready) r_bytes <= r_bytes + 48'($countones(axis_m_keep));
      if (w_s_fire && w_first && enable && w_hdr_ok && !w_ttl_ok) r_ttl_drops <= r_ttl_drops + 32'd1;
    end
  end
  assign byte_count     = r_bytes;
  assign ttl_drop_count = r_ttl_drops;
`endif
  logic w_unused;
  assign w_unused = ^axis_s_id;
endmodule

// File: tb/tb_frame_reflector.sv
// tb_frame_reflector: table vectors, hand sequences and random frames against a byte-level model
module tb_frame_reflector;
  logic         clk = 1'b0;
  logic         rst_n, enable, axis_s_valid, axis_s_ready, axis_s_last;
  logic [511:0] axis_s_data;
  logic [63:0]  axis_s_keep, axis_s_user;
  logic [2:0]   axis_s_id;
  logic         axis_m_valid, axis_m_ready, axis_m_last;
  logic [511:0] axis_m_data;
  logic [63:0]  axis_m_keep, axis_m_user;
  logic [2:0]   axis_m_id;
  logic [31:0]  reflected_count, dropped_count;
`ifdef FRAME_REFLECTOR_STATS_EN
  logic [47:0]  byte_count;
  logic [31:0]  ttl_drop_count;
`endif

  frame_reflector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .axis_s_valid(axis_s_valid), .axis_s_ready(axis_s_ready), .axis_s_data(axis_s_data),
    .axis_s_keep(axis_s_keep), .axis_s_user(axis_s_user), .axis_s_id(axis_s_id), .axis_s_last(axis_s_last),
    .axis_m_valid(axis_m_valid), .axis_m_ready(axis_m_ready), .axis_m_data(axis_m_data),
    .axis_m_keep(axis_m_keep), .axis_m_user(axis_m_user), .axis_m_id(axis_m_id), .axis_m_last(axis_m_last),
    .reflected_count(reflected_count), .dropped_count(dropped_count)
`ifdef FRAME_REFLECTOR_STATS_EN
    , .byte_count(byte_count), .ttl_drop_count(ttl_drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [63:0]  u;
    logic         l;
  } bt_t;

  typedef struct {
    logic [15:0] etype;
    logic [7:0]  ver;
    logic [7:0]  ttl;
    logic [15:0] csum;
    bit          en;
    int          len;
    bit          refl;
    logic [15:0] ocsum;
  } vec_t;

  int tests = 0, fails = 0, mode = 0, cyc = 0, stalls = 0, outs = 0;
  int mod_refl = 0, mod_drop = 0;
  bt_t exp_q[$];
  logic [7:0] fr[$];
  logic [511:0] first_out = '0;
  bit in_frame = 0, stall_prev = 0;
  bt_t prev;
  vec_t vt[11];

  task automatic chk(input string n, input logic [63:0] g, input logic [63:0] x);
    tests++;
    if (g !== x) begin
      fails++;
      $display("FAIL %s got %h expected %h", n, g, x);
    end
  endtask

  function automatic bt_t mk(input logic [7:0] q[$], input int b, input logic [63:0] u);
    bt_t x;
    x = '0;
    x.u = u;
    for (int j = 0; j < 64; j++)
      if (64*b + j < q.size()) begin
        x.d[8*j +: 8] = q[64*b + j];
        x.k[j] = 1'b1;
      end
    x.l = (64*b + 64 >= q.size());
    return x;
  endfunction

  function automatic logic [63:0] fld(input int off, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = (r << 8) | 64'(first_out[8*(off+i) +: 8]);
    return r;
  endfunction

  task automatic mkfr(input int len, input logic [15:0] et, input logic [7:0] ver,
                      input logic [7:0] ttl, input logic [15:0] cs);
    logic [271:0] h;
    h = {48'h112233445566, 48'haabbccddeeff, et, ver, 56'({$urandom, $urandom}), ttl,
         8'($urandom), cs, 32'h0a000001, 32'h0a000002};
    fr.delete();
    for (int i = 0; i < len; i++) fr.push_back(i < 34 ? h[271-8*i -: 8] : 8'($urandom));
  endtask

  // Model the whole frame as bytes, then drive it beat by beat; rb>=0 asserts reset during that beat.
  task automatic send(input bit en0, input bit en1, input int rb);
    int nb, t, c;
    logic [63:0] us[$];
    logic [7:0] e[$];
    bit ok;
    bt_t x;
    nb = (fr.size() + 63) / 64;
    for (int b = 0; b < nb; b++) us.push_back({$urandom, $urandom});
    ok = en0 && fr.size() >= 34 && fr[12] == 8'h08 && fr[13] == 8'h00 && fr[14] == 8'h45 && fr[22] >= 8'd2;
    if (ok) begin
      e = fr;
      for (int i = 0; i < 6; i++) begin e[i] = fr[i+6]; e[i+6] = fr[i]; end
      for (int i = 0; i < 4; i++) begin e[26+i] = fr[30+i]; e[30+i] = fr[26+i]; end
      e[22] = fr[22] - 8'd1;
      c = {16'd0, fr[24], fr[25]};
      if (c != 65535) begin
        c = c + 256;
        if (c > 65535) c = c - 65535;
      end
      e[24] = 8'(c >> 8);
      e[25] = 8'(c);
      for (int b = 0; b < nb; b++) exp_q.push_back(mk(e, b, us[b]));
      mod_refl++;
    end else mod_drop++;
    for (int b = 0; b < nb; b++) begin
      x = mk(fr, b, us[b]);
      axis_s_valid = 1'b1;
      axis_s_data = x.d;
      axis_s_keep = x.k;
      axis_s_user = x.u;
      axis_s_last = x.l;
      axis_s_id = 3'($urandom);
      enable = (b == 0) ? en0 : en1;
      if (b == rb) begin
        #2 rst_n = 1'b0;
        return;
      end
      t = 0;
      forever begin
        @(negedge clk);
        if (axis_s_ready) break;
        stalls++;
        if (++t > 300) begin
          chk("accept_timeout", 64'(t), 64'd0);
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    axis_s_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic mon();
    bt_t cur, e;
    cur = {axis_m_data, axis_m_keep, axis_m_user, axis_m_last};
    if (!rst_n) begin
      stall_prev = 0;
      in_frame = 0;
      return;
    end
    if (stall_prev) chk("stable", {63'd0, axis_m_valid && cur == prev}, 64'd1);
    if (axis_m_valid && axis_m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        tests++;
        if (cur !== e) begin
          fails++;
          $display("FAIL beat got d=%h k=%h u=%h l=%b expected d=%h k=%h u=%h l=%b",
                   cur.d[271:0], cur.k, cur.u, cur.l, e.d[271:0], e.k, e.u, e.l);
        end
        if (!in_frame) first_out = cur.d;
        in_frame = !cur.l;
        outs++;
      end
    end
    stall_prev = axis_m_valid && !axis_m_ready;
    prev = cur;
  endtask

  initial begin
    int r0, d0, o0, s0, kind;
    vt[0]  = '{16'h0800, 8'h45, 8'd64,  16'h1234, 1'b1, 100, 1'b1, 16'h1334};
    vt[1]  = '{16'h0800, 8'h45, 8'd64,  16'hFF80, 1'b1, 100, 1'b1, 16'h0081};
    vt[2]  = '{16'h0800, 8'h45, 8'd64,  16'hFFFF, 1'b1, 100, 1'b1, 16'hFFFF};
    vt[3]  = '{16'h86DD, 8'h45, 8'd64,  16'h1234, 1'b1, 100, 1'b0, 16'h0000};
    vt[4]  = '{16'h0800, 8'h45, 8'd1,   16'h1234, 1'b1, 100, 1'b0, 16'h0000};
    vt[5]  = '{16'h0800, 8'h45, 8'd2,   16'h00FF, 1'b1, 100, 1'b1, 16'h01FF};
    vt[6]  = '{16'h0800, 8'h46, 8'd64,  16'h1234, 1'b1, 100, 1'b0, 16'h0000};
    vt[7]  = '{16'h0800, 8'h45, 8'd64,  16'h1234, 1'b0, 200, 1'b0, 16'h0000};
    vt[8]  = '{16'h0800, 8'h45, 8'd64,  16'h1234, 1'b1, 30,  1'b0, 16'h0000};
    vt[9]  = '{16'h0800, 8'h45, 8'd64,  16'hFEFF, 1'b1, 64,  1'b1, 16'hFFFF};
    vt[10] = '{16'h0800, 8'h45, 8'd255, 16'hFF00, 1'b1, 60,  1'b1, 16'h0001};
    rst_n = 1'b0; enable = 1'b1; axis_s_valid = 1'b0; axis_s_data = '0; axis_s_keep = '0;
    axis_s_user = '0; axis_s_id = '0; axis_s_last = 1'b0; axis_m_ready = 1'b1;
    fork
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        axis_m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc / 3) % 2 == 0) : ($urandom_range(0, 3) != 0);
      end
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(axis_m_valid), 64'd0);
    chk("rst_s_ready", 64'(axis_s_ready), 64'd0);
    chk("rst_m_id", 64'(axis_m_id), 64'd0);
    chk("rst_counts", {reflected_count, dropped_count}, 64'd0);
    chk("rst_data", {62'd0, |axis_m_data, axis_m_last}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rel_s_ready_before_edge", 64'(axis_s_ready), 64'd0);
    @(posedge clk);
    #1 chk("rel_s_ready_after_edge", 64'(axis_s_ready), 64'd1);

    for (int i = 0; i < 11; i++) begin
      mkfr(vt[i].len, vt[i].etype, vt[i].ver, vt[i].ttl, vt[i].csum);
      r0 = reflected_count; d0 = dropped_count; o0 = outs;
      send(vt[i].en, 1'b1, -1);
      drain();
      chk($sformatf("v%0d_refl", i), 64'(reflected_count - r0), 64'(vt[i].refl));
      chk($sformatf("v%0d_drop", i), 64'(dropped_count - d0), 64'(!vt[i].refl));
      chk($sformatf("v%0d_beats", i), 64'(outs - o0), vt[i].refl ? 64'((vt[i].len + 63) / 64) : 64'd0);
      if (vt[i].refl) begin
        chk($sformatf("v%0d_csum", i), fld(24, 2), 64'(vt[i].ocsum));
        chk($sformatf("v%0d_ttl", i), fld(22, 1), 64'(vt[i].ttl - 8'd1));
        chk($sformatf("v%0d_dmac", i), fld(0, 6), 64'h0000aabbccddeeff);
        chk($sformatf("v%0d_smac", i), fld(6, 6), 64'h0000112233445566);
        chk($sformatf("v%0d_ips", i), fld(26, 8), 64'h0a0000020a000001);
      end
    end

    mkfr(192, 16'h0800, 8'h45, 8'd64, 16'h4321);
    s0 = stalls;
    send(1'b1, 1'b1, -1);
    chk("tput_last_out", {62'd0, axis_m_valid, axis_m_last}, 64'd3);
    chk("tput_stalls", 64'(stalls - s0), 64'd0);
    drain();

    mode = 1;
    for (int f = 0; f < 4; f++) begin
      mkfr($urandom_range(130, 250), 16'h0800, 8'h45, 8'($urandom_range(2, 255)), 16'($urandom));
      send(1'b1, 1'b1, -1);
    end
    drain();
    chk("bp_refl", 64'(reflected_count), 64'(mod_refl));
    chk("bp_drop", 64'(dropped_count), 64'(mod_drop));

    mode = 2;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 5);
      mkfr($urandom_range(20, 260), kind == 1 ? 16'h86DD : 16'h0800, kind == 2 ? 8'h46 : 8'h45,
           kind == 3 ? 8'($urandom_range(0, 3)) : 8'($urandom_range(2, 255)), 16'($urandom));
      send(kind != 4, 1'($urandom), -1);
    end
    drain();
    chk("rand_refl", 64'(reflected_count), 64'(mod_refl));
    chk("rand_drop", 64'(dropped_count), 64'(mod_drop));

    mode = 0;
    mkfr(150, 16'h0800, 8'h45, 8'd64, 16'h1111);
    send(1'b1, 1'b1, 2);
    #1;
    chk("mrst_m_valid", 64'(axis_m_valid), 64'd0);
    chk("mrst_s_ready", 64'(axis_s_ready), 64'd0);
    chk("mrst_counts", {reflected_count, dropped_count}, 64'd0);
    chk("mrst_data", {62'd0, |axis_m_data, axis_m_last}, 64'd0);
    exp_q.delete();
    mod_refl = 0; mod_drop = 0;
    axis_s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    mkfr(100, 16'h0800, 8'h45, 8'd64, 16'hFF80);
    send(1'b1, 1'b1, -1);
    drain();
    chk("mrst_after_refl", 64'(reflected_count), 64'd1);
    chk("mrst_after_csum", fld(24, 2), 64'h0081);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
